// File: rtl/fpu_alt_inp_sched.sv
// Round-robin scheduler for the shared ALT operand injection path of FPU pair 2.
// Drives ALTDATA0/1 and ALT_INP, tracks each op through a LAT-deep tag pipe and returns tagged results.
module fpu_alt_inp_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 68,
  parameter int unsigned LAT  = 4,
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_vld,
  input  logic [2*NREQ-1:0]     req_lane,
  input  logic [W*NREQ-1:0]     req_d0,
  input  logic [W*NREQ-1:0]     req_d1,
  output logic [NREQ-1:0]       req_rdy,
  input  logic [1:0]            lane_free,
  input  logic                  flush,
  output logic [W-1:0]          ALTDATA0,
  output logic [W-1:0]          ALTDATA1,
  output logic [1:0]            ALT_INP,
  input  logic [W-1:0]          outA,
  input  logic [W-1:0]          outB,
  output logic                  rsp_vld,
  output logic [IDW-1:0]        rsp_id,
  output logic [1:0]            rsp_lane,
  output logic [W-1:0]          rsp_A,
  output logic [W-1:0]          rsp_B
);

  typedef struct packed {
    logic           v;
    logic [IDW-1:0] id;
    logic [1:0]     lane;
  } tag_t;

  logic [1:0]     lane_a [NREQ];
  logic [W-1:0]   d0_a   [NREQ];
  logic [W-1:0]   d1_a   [NREQ];
  logic [NREQ-1:0] elig;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] scan_idx;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  logic [1:0]     gnt_lane;
  tag_t           tag_q [LAT];

  // Unpack per-requester fields; a request is eligible only if every lane it needs is free.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      lane_a[i] = req_lane[2*i +: 2];
      d0_a[i]   = req_d0[W*i +: W];
      d1_a[i]   = req_d1[W*i +: W];
      elig[i]   = req_vld[i] & (|lane_a[i]) & ((lane_a[i] & ~lane_free) == 2'b00) & ~flush & rst;
    end
  end

  // First eligible requester at or after rr_ptr wins.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_id   = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = IDW'((32'(rr_ptr) + k) % NREQ);
      if (!gnt_vld && elig[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = scan_idx;
      end
    end
  end

  always_comb begin
    req_rdy  = '0;
    gnt_lane = lane_a[gnt_id];
    if (gnt_vld) req_rdy[gnt_id] = 1'b1;
  end

  // Injection registers and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr   <= '0;
      ALT_INP  <= 2'b00;
      ALTDATA0 <= '0;
      ALTDATA1 <= '0;
    end else begin
      ALT_INP <= gnt_vld ? gnt_lane : 2'b00;
      if (gnt_vld) rr_ptr <= IDW'((32'(gnt_id) + 32'd1) % NREQ);
      if (gnt_vld && gnt_lane[0]) ALTDATA0 <= d0_a[gnt_id];
      if (gnt_vld && gnt_lane[1]) ALTDATA1 <= d1_a[gnt_id];
    end
  end

  // Tag pipe mirrors the FPU latency; flush kills every stage at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < LAT; k++) tag_q[k] <= '0;
    end else if (flush) begin
      for (int unsigned k = 0; k < LAT; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= '{v: gnt_vld, id: gnt_id, lane: gnt_lane};
      for (int unsigned k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  // Response capture when the oldest tag lines up with valid FPU results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_vld  <= 1'b0;
      rsp_id   <= '0;
      rsp_lane <= 2'b00;
      rsp_A    <= '0;
      rsp_B    <= '0;
    end else begin
      rsp_vld <= tag_q[LAT-1].v & ~flush;
      if (tag_q[LAT-1].v && !flush) begin
        rsp_id   <= tag_q[LAT-1].id;
        rsp_lane <= tag_q[LAT-1].lane;
        rsp_A    <= outA;
        rsp_B    <= outB;
      end
    end
  end

endmodule
